// File: rtl/divider_unit.sv
// divider_unit: iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per cycle. Divide-by-zero and
// signed overflow bypass the iteration and complete on the accept edge.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   div_din1          dividend
//   div_din2          divisor
//   div_op            00 DIV, 01 DIVU, 10 REM, 11 REMU
//   div_in_valid      operation request
//   div_in_ready      unit idle and able to accept
//   div_kill          flush: abort and drop any operation or result
//   div_dout          quotient or remainder
//   div_out_valid     div_dout valid, held until consumed
//   div_out_ready     consumer takes the result
module divider_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] div_din1,
    input  logic [DATA_WIDTH-1:0] div_din2,
    input  logic [1:0]            div_op,
    input  logic                  div_in_valid,
    output logic                  div_in_ready,
    input  logic                  div_kill,
    output logic [DATA_WIDTH-1:0] div_dout,
    output logic                  div_out_valid,
    input  logic                  div_out_ready
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] divisor_q, divisor_d;
    logic [1:0]            op_q, op_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  out_valid_q, out_valid_d;

    logic                  in_signed;
    logic                  accept;
    logic [DATA_WIDTH-1:0] abs1, abs2;
    logic [DATA_WIDTH:0]   rem_shift, diff;
    logic                  ge;
    logic [DATA_WIDTH-1:0] quo_iter, rem_iter;

    assign div_in_ready  = (state_q == StIdle) & ~rst;
    assign div_dout      = dout_q;
    assign div_out_valid = out_valid_q;

    always_comb begin
        in_signed = ~div_op[0];
        accept    = div_in_valid & div_in_ready & ~div_kill;
        // MinNeg negates to itself, which is its correct unsigned magnitude.
        abs1      = (in_signed & div_din1[DATA_WIDTH-1]) ? -div_din1 : div_din1;
        abs2      = (in_signed & div_din2[DATA_WIDTH-1]) ? -div_din2 : div_din2;

        // One restoring step; diff[MSB] is the borrow of the trial subtract.
        rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
        diff      = rem_shift - {1'b0, divisor_q};
        ge        = ~diff[DATA_WIDTH];
        rem_iter  = ge ? diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
        quo_iter  = {quo_q[DATA_WIDTH-2:0], ge};

        state_d     = state_q;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        op_d        = op_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = div_op;
                    neg_quo_d = in_signed & (div_din1[DATA_WIDTH-1] ^ div_din2[DATA_WIDTH-1]);
                    neg_rem_d = in_signed & div_din1[DATA_WIDTH-1];
                    quo_d     = abs1;
                    divisor_d = abs2;
                    rem_d     = '0;
                    cnt_d     = CntLast;
                    if (div_din2 == '0) begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        dout_d      = div_op[1] ? div_din1 : '1;
                    end else if (in_signed && div_din1 == MinNeg && div_din2 == '1) begin
                        state_d     = StDone;
                        out_valid_d = 1'b1;
                        dout_d      = div_op[1] ? '0 : div_din1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                quo_d = quo_iter;
                rem_d = rem_iter;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d       = '0;
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    case (op_q)
                        2'b00:   dout_d = neg_quo_q ? -quo_iter : quo_iter;
                        2'b01:   dout_d = quo_iter;
                        2'b10:   dout_d = neg_rem_q ? -rem_iter : rem_iter;
                        default: dout_d = rem_iter;
                    endcase
                end
            end
            StDone: begin
                if (div_out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush wins over both handshakes.
        if (div_kill) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            op_q        <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            op_q        <= op_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
